// File: rtl/xw_pipe_reg.sv
// X -> W pipeline register for the 3-stage RV32I core.
// Captures the executing instruction, PC and ALU result, formats load data
// and writeback data, and is the only source of the stage-3 instruction and
// value used by rs1/rs2 forwarding. A load followed by a dependent instruction
// costs one bubble. During that bubble the load is replayed from a local buffer
// as the forwarding source.
//
// Handshake: there is no valid/ready pair here.
// - x_valid qualifies the X slot.
// - lu_stall asks the front end to hold X for the current cycle.
// - stall_in freezes every register of this block.
module xw_pipe_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        x_valid,
  input  logic [31:0] x_inst,
  input  logic [31:0] x_pc,
  input  logic [31:0] x_alu_out,
  input  logic [31:0] mem_rdata,
  output logic        w_valid,
  output logic [31:0] w_inst,
  output logic [31:0] w_pc,
  output logic [31:0] w_alu_out,
  output logic [31:0] w_wb_data,
  output logic [31:0] fwd_inst,
  output logic [31:0] fwd_data,
  output logic        lu_stall,
  output logic        dbg_state   // 0 = RUN, 1 = LU (load-use replay)
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {ST_RUN = 1'b0, ST_LU = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        w_valid_q, w_valid_d;
  logic [31:0] w_inst_q, w_inst_d;
  logic [31:0] w_pc_q, w_pc_d;
  logic [31:0] w_alu_q, w_alu_d;
  logic [31:0] ld_buf_q, ld_buf_d;
  logic [31:0] held_inst_q, held_inst_d;

  logic [6:0]  w_op;
  logic [6:0]  x_op;
  logic [4:0]  w_rd;
  logic [4:0]  x_rs1;
  logic [4:0]  x_rs2;
  logic        x_uses_rs1;
  logic        x_uses_rs2;
  logic        hazard;
  logic [31:0] ld_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign w_op  = w_inst_q[6:0];
  assign w_rd  = w_inst_q[11:7];
  assign x_op  = x_inst[6:0];
  assign x_rs1 = x_inst[19:15];
  assign x_rs2 = x_inst[24:20];

  // Decode which source registers the X instruction actually reads
  always_comb begin
    x_uses_rs1 = !((x_op == OP_LUI) || (x_op == OP_AUIPC) || (x_op == OP_JAL));
    x_uses_rs2 = (x_op == OP_BRANCH) || (x_op == OP_STORE) || (x_op == OP_OP);
  end

  // Load-use hazard: a load in W feeds an X instruction; only checked in RUN
  always_comb begin
    hazard = 1'b0;
    if ((state_q == ST_RUN) && w_valid_q && (w_op == OP_LOAD) &&
        (w_rd != 5'd0) && x_valid) begin
      hazard = (x_uses_rs1 && (x_rs1 == w_rd)) ||
               (x_uses_rs2 && (x_rs2 == w_rd));
    end
  end

  assign lu_stall = hazard;

  // Align and extend the raw memory word by funct3 and the low address bits
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (w_alu_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = w_alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_inst_q[14:12])
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // Writeback value selected by the W opcode; link address wraps mod 2^32
  always_comb begin
    if (w_op == OP_LOAD) begin
      w_wb_data = ld_fmt;
    end else if ((w_op == OP_JAL) || (w_op == OP_JALR)) begin
      w_wb_data = w_pc_q + 32'd4;
    end else begin
      w_wb_data = w_alu_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  // A flush still enters LU when the W load was hazarding, so the load
  // stays available for forwarding.
  always_comb begin
    state_d = state_q;
    if (!stall_in) begin
      case (state_q)
        ST_RUN:  if (hazard) state_d = ST_LU;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM outputs: forwarding source is W in RUN, the replayed load in LU
  always_comb begin
    if (state_q == ST_LU) begin
      fwd_inst = held_inst_q;
      fwd_data = ld_buf_q;
    end else begin
      fwd_inst = w_inst_q;
      fwd_data = w_wb_data;
    end
  end

  assign dbg_state = state_q;

  // Capture selection with priority stall_in > flush > load-use > normal
  always_comb begin
    w_valid_d   = w_valid_q;
    w_inst_d    = w_inst_q;
    w_pc_d      = w_pc_q;
    w_alu_d     = w_alu_q;
    ld_buf_d    = ld_buf_q;
    held_inst_d = held_inst_q;
    if (!stall_in) begin
      if (hazard) begin
        ld_buf_d    = ld_fmt;
        held_inst_d = w_inst_q;
      end
      if (flush) begin
        w_valid_d = 1'b0;
        w_inst_d  = NOP_INST;
        w_pc_d    = x_pc;
        w_alu_d   = 32'd0;
      end else if (hazard) begin
        w_valid_d = 1'b0;
        w_inst_d  = NOP_INST;
        w_alu_d   = 32'd0;
      end else begin
        w_valid_d = x_valid;
        w_inst_d  = x_inst;
        w_pc_d    = x_pc;
        w_alu_d   = x_alu_out;
      end
    end
  end

  // Pipeline and load-buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_q   <= 1'b0;
      w_inst_q    <= NOP_INST;
      w_pc_q      <= RESET_PC;
      w_alu_q     <= 32'd0;
      ld_buf_q    <= 32'd0;
      held_inst_q <= NOP_INST;
    end else begin
      w_valid_q   <= w_valid_d;
      w_inst_q    <= w_inst_d;
      w_pc_q      <= w_pc_d;
      w_alu_q     <= w_alu_d;
      ld_buf_q    <= ld_buf_d;
      held_inst_q <= held_inst_d;
    end
  end

  assign w_valid   = w_valid_q;
  assign w_inst    = w_inst_q;
  assign w_pc      = w_pc_q;
  assign w_alu_out = w_alu_q;

endmodule

// File: tb/tb_xw_pipe_reg.sv
// Directed bench for xw_pipe_reg.
// Inputs change 1 ns after a rising edge; outputs are checked 2 ns after it.
module tb_xw_pipe_reg;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] I_ADDI5   = 32'h0070_0293; // addi x5,x0,7
  localparam logic [31:0] I_ADD655  = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] I_LW5     = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD650  = 32'h0002_8333; // add  x6,x5,x0
  localparam logic [31:0] I_LB7     = 32'h0030_0383; // lb   x7,3(x0)
  localparam logic [31:0] I_LHU7    = 32'h0020_5383; // lhu  x7,2(x0)
  localparam logic [31:0] I_LH7     = 32'h0020_1383; // lh   x7,2(x0)
  localparam logic [31:0] I_LBU7    = 32'h0010_4383; // lbu  x7,1(x0)
  localparam logic [31:0] I_JAL1    = 32'h0000_00EF; // jal  x1,0

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        flush;
  logic        x_valid;
  logic [31:0] x_inst;
  logic [31:0] x_pc;
  logic [31:0] x_alu_out;
  logic [31:0] mem_rdata;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic [31:0] w_alu_out;
  logic [31:0] w_wb_data;
  logic [31:0] fwd_inst;
  logic [31:0] fwd_data;
  logic        lu_stall;
  logic        dbg_state;

  int checks;
  int failures;

  xw_pipe_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_in  (stall_in),
    .flush     (flush),
    .x_valid   (x_valid),
    .x_inst    (x_inst),
    .x_pc      (x_pc),
    .x_alu_out (x_alu_out),
    .mem_rdata (mem_rdata),
    .w_valid   (w_valid),
    .w_inst    (w_inst),
    .w_pc      (w_pc),
    .w_alu_out (w_alu_out),
    .w_wb_data (w_wb_data),
    .fwd_inst  (fwd_inst),
    .fwd_data  (fwd_data),
    .lu_stall  (lu_stall),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in the X slot
  task automatic drive_x(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] alu);
    x_valid   = v;
    x_inst    = inst;
    x_pc      = pc;
    x_alu_out = alu;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    stall_in  = 1'b0;
    flush     = 1'b0;
    mem_rdata = 32'd0;
    drive_x(1'b0, NOP, 32'd0, 32'd0);
    checks    = 0;
    failures  = 0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_w_inst",   w_inst, NOP);
    chk("rst_fwd_inst", fwd_inst, NOP);
    chk("rst_w_valid",  {31'd0, w_valid}, 32'd0);
    chk("rst_w_pc",     w_pc, 32'd0);
    chk("rst_w_alu",    w_alu_out, 32'd0);
    chk("rst_lu_stall", {31'd0, lu_stall}, 32'd0);
    chk("rst_state",    {31'd0, dbg_state}, 32'd0);

    // Back-to-back ALU ops: the dependent add forwards from W without a stall
    tick();
    drive_x(1'b1, I_ADDI5, 32'h100, 32'd7);
    tick();
    drive_x(1'b1, I_ADD655, 32'h104, 32'd14);
    #1;
    chk("alu_lu_stall", {31'd0, lu_stall}, 32'd0);
    chk("alu_fwd_inst", fwd_inst, I_ADDI5);
    chk("alu_fwd_data", fwd_data, 32'd7);
    chk("alu_w_pc",     w_pc, 32'h100);
    chk("alu_w_valid",  {31'd0, w_valid}, 32'd1);
    tick();
    #1;
    chk("alu2_w_inst",  w_inst, I_ADD655);
    chk("alu2_wb_data", w_wb_data, 32'd14);

    // Load-use: one bubble, then the load is replayed as forwarding source
    drive_x(1'b1, I_LW5, 32'h108, 32'h1000);
    tick();
    drive_x(1'b1, I_ADD650, 32'h10C, 32'd0);
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lu_stall_hi",  {31'd0, lu_stall}, 32'd1);
    chk("lu_wb_data",   w_wb_data, 32'hDEAD_BEEF);
    tick();
    mem_rdata = 32'h0;
    #1;
    chk("lu_stall_lo",  {31'd0, lu_stall}, 32'd0);
    chk("lu_bubble_v",  {31'd0, w_valid}, 32'd0);
    chk("lu_bubble_i",  w_inst, NOP);
    chk("lu_fwd_inst",  fwd_inst, I_LW5);
    chk("lu_fwd_data",  fwd_data, 32'hDEAD_BEEF);
    chk("lu_state",     {31'd0, dbg_state}, 32'd1);
    tick();
    #1;
    chk("lu_run_state", {31'd0, dbg_state}, 32'd0);
    chk("lu_run_inst",  w_inst, I_ADD650);
    chk("lu_run_pc",    w_pc, 32'h10C);

    // Load formatting
    drive_x(1'b1, I_LB7, 32'h110, 32'h2003);
    tick();
    drive_x(1'b0, NOP, 32'h114, 32'd0);
    mem_rdata = 32'h8011_2233;
    #1;
    chk("lb_addr3",     w_wb_data, 32'hFFFF_FF80);
    drive_x(1'b1, I_LHU7, 32'h114, 32'h2002);
    tick();
    drive_x(1'b1, I_LH7, 32'h118, 32'h2003);
    #1;
    chk("lhu_addr2",    w_wb_data, 32'h0000_8011);
    tick();
    drive_x(1'b1, I_LBU7, 32'h11C, 32'h2001);
    #1;
    chk("lh_addr3",     w_wb_data, 32'hFFFF_8011);
    tick();
    drive_x(1'b0, NOP, 32'h120, 32'd0);
    #1;
    chk("lbu_addr1",    w_wb_data, 32'h0000_0022);

    // JAL link address wraps; flush kills the X instruction
    drive_x(1'b1, I_JAL1, 32'hFFFF_FFFC, 32'h1234_5678);
    tick();
    drive_x(1'b1, I_ADD655, 32'h200, 32'd99);
    flush = 1'b1;
    #1;
    chk("jal_wrap",     w_wb_data, 32'h0000_0000);
    tick();
    flush = 1'b0;
    drive_x(1'b0, NOP, 32'h204, 32'd0);
    #1;
    chk("flush_valid",  {31'd0, w_valid}, 32'd0);
    chk("flush_inst",   w_inst, NOP);
    chk("flush_pc",     w_pc, 32'h200);

    // External stall held for three cycles while in LU
    drive_x(1'b1, I_LW5, 32'h300, 32'h1004);
    tick();
    drive_x(1'b1, I_ADD650, 32'h304, 32'd0);
    mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("st_lu_stall",  {31'd0, lu_stall}, 32'd1);
    tick();
    stall_in  = 1'b1;
    mem_rdata = 32'h0;
    #1;
    chk("st_enter_lu",  {31'd0, dbg_state}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("st_hold_state", {31'd0, dbg_state}, 32'd1);
      chk("st_hold_valid", {31'd0, w_valid}, 32'd0);
      chk("st_hold_inst",  w_inst, NOP);
      chk("st_hold_fwdi",  fwd_inst, I_LW5);
      chk("st_hold_fwdd",  fwd_data, 32'h0BAD_F00D);
      chk("st_hold_lus",   {31'd0, lu_stall}, 32'd0);
    end
    stall_in = 1'b0;
    tick();
    #1;
    chk("st_resume_state", {31'd0, dbg_state}, 32'd0);
    chk("st_resume_inst",  w_inst, I_ADD650);
    chk("st_resume_valid", {31'd0, w_valid}, 32'd1);

    // Asynchronous reset in the middle of traffic
    drive_x(1'b1, I_LW5, 32'h400, 32'h1008);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_w_inst",   w_inst, NOP);
    chk("mrst_fwd_inst", fwd_inst, NOP);
    chk("mrst_w_valid",  {31'd0, w_valid}, 32'd0);
    chk("mrst_w_pc",     w_pc, 32'd0);
    chk("mrst_lu_stall", {31'd0, lu_stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    drive_x(1'b0, NOP, 32'd0, 32'd0);
    tick();
    #1;
    chk("mrst_after_v",  {31'd0, w_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
